uart_rx_wr: RTL and testbench
=============================

UART_RX_WR -- requirements
Module: uart_rx_wr

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 27, meaning wr_clk cycles per 16x-oversample tick (50 MHz / 115200 / 16).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame.
REQ-003 SHALL have port wr_clk, input, 1, the single clock for the block.
REQ-004 SHALL have port wr_reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port wr_full, input, 1, registered full flag from the FIFO write-pointer stage.
REQ-007 SHALL have port err_clr, input, 1, single-cycle clear of the sticky overrun flag.
REQ-008 SHALL have port wr_en, output, 1, one-cycle write strobe to the FIFO.
REQ-009 SHALL have port wr_data, output, DATA_BITS, received byte, valid while wr_en is high.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1, sticky flag set when a good byte is dropped because wr_full is high.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 SHALL generate a tick every BAUD_DIV wr_clk cycles and SHALL restart the divider on start-edge detection.
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-015 IDLE: a synchronized 1->0 transition SHALL move to START and clear the tick and bit counters.
REQ-016 START: after 8 ticks, a sample of 0 SHALL move to DATA; a sample of 1 SHALL be treated as a glitch and return to IDLE with no output.
REQ-017 DATA: SHALL sample every 16 ticks and shift LSB-first; after DATA_BITS samples SHALL move to PARITY if enabled, otherwise to STOP.
REQ-018 STOP: SHALL sample after 16 ticks; 1 = good frame and return to IDLE; 0 = framing error and move to WAIT_IDLE.
REQ-019 WAIT_IDLE: SHALL return to IDLE only after the synchronized rx has been high for one full tick.
REQ-020 On a good frame with wr_full=0, wr_en SHALL pulse high for exactly the one wr_clk cycle following the stop-sample tick, with wr_data stable in that cycle.
REQ-021 On a good frame with wr_full=1 in the stop-sample cycle, the byte SHALL be dropped, wr_en SHALL stay low, and overrun SHALL be set.
REQ-022 frame_err SHALL pulse for one cycle on a bad stop bit, and no write SHALL occur.
REQ-023 overrun SHALL clear on err_clr unless a new overrun occurs in the same cycle, in which case set wins.
REQ-024 wr_en SHALL never be high in two consecutive cycles.

Reset
REQ-025 When wr_reset_n=0 at a wr_clk edge, the state SHALL become IDLE, all counters 0, wr_en/frame_err/parity_err/overrun 0, wr_data 0, and the synchronizer flops 1.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no write, and the next start edge SHALL be received normally.

Configuration
REQ-027 Macro UART_PARITY_EN defined: SHALL include the PARITY state, which samples an even-parity bit 16 ticks after the last data bit, and SHALL provide output port parity_err (1 bit), a one-cycle pulse on mismatch.
REQ-028 With UART_PARITY_EN defined, a frame with a parity mismatch SHALL NOT be written, even if its stop bit is good.
REQ-029 Macro UART_PARITY_EN undefined: SHALL have no PARITY state and no parity_err port, and the frame SHALL be start + DATA_BITS + stop.

Structure
REQ-030 The state encoding and the OVERSAMPLE=16 and MID_SAMPLE=8 constants SHALL live in shared package uart_pkg.
REQ-031 The tick divider SHALL be a separate sub-module, uart_baud_tick, with inputs wr_clk, wr_reset_n and restart, and output tick.

Verification
REQ-032 A frame carrying 0xA5 with wr_full=0 SHALL produce exactly one wr_en pulse with wr_data=0xA5, about 10*16*27 cycles after the start edge.
REQ-033 A 3-tick low glitch on rx SHALL produce no wr_en and no frame_err, and the state SHALL return to IDLE.
REQ-034 A frame carrying 0x3C with the stop bit forced 0 SHALL produce a frame_err pulse and no wr_en, then a following 0x11 frame SHALL be received correctly after rx returns high.
REQ-035 A frame carrying 0x7E with wr_full=1 SHALL produce no wr_en and overrun=1, which SHALL hold until an err_clr pulse returns it to 0.
REQ-036 With UART_PARITY_EN defined, a frame carrying 0x01 with parity bit 0 SHALL produce a parity_err pulse and no wr_en; with parity bit 1 it SHALL be written.
REQ-037 Taking wr_reset_n low during data bit 4 of a frame carrying 0xFF SHALL produce no write, and a following frame carrying 0x55 SHALL give wr_data=0x55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and receiver state encoding for the UART write-side receiver.
// The PARITY state exists only when UART_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// 16x-oversample tick generator: a down-counter that fires on terminal count
// and is re-phased by restart so sampling lines up with the start edge.
module uart_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic wr_clk,
    input  logic wr_reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (restart || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end
    end

    assign tick = (cnt_q == '0) && !restart;

    always_ff @(posedge wr_clk) begin
        if (!wr_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_wr.sv
// UART receiver that writes each good byte straight into a FIFO write port.
// Define UART_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_wr
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 27,
    parameter int DATA_BITS = 8
) (
    input  logic                 wr_clk,
    input  logic                 wr_reset_n,
    input  logic                 rx,
    input  logic                 wr_full,
    input  logic                 err_clr,
    output logic                 wr_en,
    output logic [DATA_BITS-1:0] wr_data,
    output logic                 frame_err,
`ifdef UART_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    localparam int BW = $clog2(DATA_BITS + 1);

    rx_state_e state_q, state_d;
    logic rx_s1_q, rx_s2_q, rx_s3_q;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic wr_en_q, wr_en_d;
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;
    logic ovr_set;
    logic par_ok;
    logic restart;
    logic tick;
    logic tick_mid;
    logic tick_last;
`ifdef UART_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic parity_err_q, parity_err_d;
`endif

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .wr_clk     (wr_clk),
        .wr_reset_n (wr_reset_n),
        .restart    (restart),
        .tick       (tick)
    );

    assign tick_mid  = tick && (tick_cnt_q == 4'(MID_SAMPLE - 1));
    assign tick_last = tick && (tick_cnt_q == 4'(OVERSAMPLE - 1));

`ifdef UART_PARITY_EN
    assign par_ok = !par_bad_q;
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;
        ovr_set     = 1'b0;
        restart     = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s2_q && rx_s3_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    restart    = 1'b1;
`ifdef UART_PARITY_EN
                    par_bad_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (tick_mid) begin
                    tick_cnt_d = '0;
                    state_d    = rx_s2_q ? IDLE : DATA;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end
            end
            DATA: begin
                if (tick_last) begin
                    tick_cnt_d = '0;
                    shreg_d    = {rx_s2_q, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (tick_last) begin
                    tick_cnt_d   = '0;
                    par_bad_d    = ^{shreg_q, rx_s2_q};
                    parity_err_d = ^{shreg_q, rx_s2_q};
                    state_d      = STOP;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end
            end
`endif
            STOP: begin
                if (tick_last) begin
                    tick_cnt_d = '0;
                    if (rx_s2_q) begin
                        state_d = IDLE;
                        if (par_ok) begin
                            if (wr_full) begin
                                ovr_set = 1'b1;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_data_d = shreg_q;
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end
            end
            WAIT_IDLE: begin
                // tick_cnt marks that a tick has been seen with rx high; the
                // next tick with rx still high closes one full high interval.
                if (!rx_s2_q) begin
                    tick_cnt_d = '0;
                end else if (tick) begin
                    if (tick_cnt_q != '0) begin
                        state_d = IDLE;
                    end
                    tick_cnt_d = 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        overrun_d = (overrun_q && !err_clr) || ovr_set;
    end

    always_ff @(posedge wr_clk) begin
        if (!wr_reset_n) begin
            state_q     <= IDLE;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_wr.sv
// Self-checking bench for uart_rx_wr: vector table, hand-written corner cases
// and random frames checked against a frame-level outcome model.
module tb_uart_rx_wr;

    localparam int B   = 8;
    localparam int DB  = 8;
    localparam int BIT = 16 * B;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic          wr_clk = 1'b0;
    logic          wr_reset_n = 1'b0;
    logic          rx = 1'b1;
    logic          wr_full = 1'b0;
    logic          err_clr = 1'b0;
    logic          wr_en;
    logic [DB-1:0] wr_data;
    logic          frame_err;
    logic          overrun;
`ifdef UART_PARITY_EN
    logic          parity_err;
`endif

    uart_rx_wr #(.BAUD_DIV(B), .DATA_BITS(DB)) dut (
        .wr_clk     (wr_clk),
        .wr_reset_n (wr_reset_n),
        .rx         (rx),
        .wr_full    (wr_full),
        .err_clr    (err_clr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .frame_err  (frame_err),
`ifdef UART_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    always #5 wr_clk = ~wr_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_cnt = 0, ferr_cnt = 0, perr_cnt = 0, dbl_cnt = 0;
    int last_wr_cyc = 0;
    int start_cyc = 0;
    logic [DB-1:0] last_data = '0;
    logic wr_en_prev = 1'b0;

    always @(posedge wr_clk) cyc++;

    always @(negedge wr_clk) begin
        if (wr_en === 1'b1) begin
            wr_cnt++;
            last_data   = wr_data;
            last_wr_cyc = cyc;
            if (wr_en_prev) dbl_cnt++;
        end
        wr_en_prev = (wr_en === 1'b1);
        if (frame_err === 1'b1) ferr_cnt++;
`ifdef UART_PARITY_EN
        if (parity_err === 1'b1) perr_cnt++;
`endif
    end

    typedef struct {
        logic [7:0] d;
        logic       stop_v;
        logic       flip;
        logic       full;
        logic       exp_wr;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
        logic       exp_ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        repeat (BIT) @(posedge wr_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic flip);
        start_cyc = cyc;
        bit_out(1'b0);
        for (int i = 0; i < DB; i++) bit_out(d[i]);
        if (PB == 1) bit_out((^d) ^ flip);
        bit_out(stop_v);
        rx = 1'b1;
    endtask

    // Frame-level outcome: what the line carries decides what the FIFO sees.
    function automatic void predict(input logic stop_v, input logic flip, input logic full,
                                    output logic wr, output logic ferr, output logic perr,
                                    output logic ovr_set);
        logic good;
        perr    = (PB == 1) && flip;
        ferr    = !stop_v;
        good    = stop_v && !perr;
        wr      = good && !full;
        ovr_set = good && full;
    endfunction

    task automatic run_frame(input string tag, input vec_t v, input bit check_lat);
        int w0, f0, p0, lat, lat_exp;
        wr_full = v.full;
        w0 = wr_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(v.d, v.stop_v, v.flip);
        repeat (2 * BIT) @(posedge wr_clk);
        #1;
        chk({tag, "_wr"}, 32'(wr_cnt - w0), 32'(v.exp_wr));
        if (v.exp_wr) chk({tag, "_data"}, 32'(last_data), 32'(v.exp_data));
        chk({tag, "_ferr"}, 32'(ferr_cnt - f0), 32'(v.exp_ferr));
        if (PB == 1) chk({tag, "_perr"}, 32'(perr_cnt - p0), 32'(v.exp_perr));
        chk({tag, "_ovr"}, 32'(overrun), 32'(v.exp_ovr));
        if (check_lat) begin
            lat     = last_wr_cyc - start_cyc;
            lat_exp = (8 + 16 * (DB + PB + 1)) * B;
            chk({tag, "_lat_ok"}, 32'((lat >= lat_exp) && (lat <= lat_exp + 8)), 32'd1);
        end
        wr_full = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge wr_clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        int w0, f0;
        logic ovr_model;
        vec_t v;

        tbl.push_back('{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1});
`ifdef UART_PARITY_EN
        tbl.push_back('{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1});
`endif

        repeat (5) @(posedge wr_clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
`ifdef UART_PARITY_EN
        chk("rst_parity_err", 32'(parity_err), 32'd0);
`endif
        wr_reset_n = 1'b1;
        repeat (BIT) @(posedge wr_clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i], i == 0);
        end

        chk("ovr_held", 32'(overrun), 32'd1);
        pulse_clr();
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Short low glitch must be rejected at the mid-start sample.
        w0 = wr_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (3 * B) @(posedge wr_clk);
        #1;
        rx = 1'b1;
        repeat (2 * BIT) @(posedge wr_clk);
        #1;
        chk("glitch_wr", 32'(wr_cnt - w0), 32'd0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        v = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0};
        run_frame("post_glitch", v, 1'b0);

        ovr_model = 1'b0;
        for (int i = 0; i < 12; i++) begin
            logic ovr_set;
            if ($urandom_range(0, 2) == 0) begin
                pulse_clr();
                ovr_model = 1'b0;
            end
            v.d      = 8'($urandom);
            v.stop_v = ($urandom_range(0, 4) != 0);
            v.flip   = (PB == 1) && ($urandom_range(0, 3) == 0);
            v.full   = ($urandom_range(0, 3) == 0);
            predict(v.stop_v, v.flip, v.full, v.exp_wr, v.exp_ferr, v.exp_perr, ovr_set);
            v.exp_data = v.d;
            ovr_model  = ovr_model | ovr_set;
            v.exp_ovr  = ovr_model;
            run_frame($sformatf("rnd%0d", i), v, 1'b0);
        end

        // Reset in the middle of data bit 4 of an all-ones frame.
        w0 = wr_cnt;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        rx = 1'b1;
        repeat (BIT / 2) @(posedge wr_clk);
        #1;
        wr_reset_n = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;
        wr_reset_n = 1'b1;
        repeat (BIT * 5) @(posedge wr_clk);
        #1;
        chk("midrst_wr", 32'(wr_cnt - w0), 32'd0);
        chk("midrst_ovr", 32'(overrun), 32'd0);
        v = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        run_frame("after_rst", v, 1'b0);

        chk("wr_en_back_to_back", 32'(dbl_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
